// File: rtl/peripheral_bfm_master_axi4_lite.sv
// AXI4-Lite bus-functional master: issues one read or write per command, checks masked
// read data, enforces a per-handshake timeout and keeps a sticky test_fail flag.
module peripheral_bfm_master_axi4_lite #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   localparam int unsigned STRB_WIDTH    = DATA_WIDTH / 8
) (
   input  logic                  aclk,
   input  logic                  areset,
   // command / response
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [STRB_WIDTH-1:0] cmd_wstrb,
   input  logic [DATA_WIDTH-1:0] cmd_mask,
   input  logic [DATA_WIDTH-1:0] cmd_expected,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic                  rsp_mismatch,
   output logic                  rsp_timeout,
   output logic                  test_fail,
   // AXI4-Lite master
   output logic [ADDR_WIDTH-1:0] awaddr,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic [STRB_WIDTH-1:0] wstrb,
   output logic                  wvalid,
   input  logic                  wready,
   input  logic [1:0]            bresp,
   input  logic                  bvalid,
   output logic                  bready,
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic                  arvalid,
   input  logic                  arready,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic [1:0]            rresp,
   input  logic                  rvalid,
   output logic                  rready
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StWrReq,
      StWrResp,
      StRdReq,
      StRdData,
      StDone
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic [DATA_WIDTH-1:0] mask_q;
   logic [DATA_WIDTH-1:0] expected_q;
   logic                  aw_pend_q, aw_pend_d;
   logic                  w_pend_q, w_pend_d;
   logic [CntW-1:0]       wait_cnt_q;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            resp_q, resp_d;
   logic                  mismatch_q, mismatch_d;
   logic                  timeout_q, timeout_d;
   logic                  test_fail_q, test_fail_d;
   logic                  accept;
   logic                  in_wait;

   assign in_wait = (state_q == StWrReq) || (state_q == StWrResp) ||
                    (state_q == StRdReq) || (state_q == StRdData);

   always_comb begin
      state_d    = state_q;
      aw_pend_d  = aw_pend_q;
      w_pend_d   = w_pend_q;
      rdata_d    = rdata_q;
      resp_d     = resp_q;
      mismatch_d = mismatch_q;
      timeout_d  = timeout_q;
      accept     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               accept     = 1'b1;
               state_d    = cmd_write ? StWrReq : StRdReq;
               aw_pend_d  = cmd_write;
               w_pend_d   = cmd_write;
               rdata_d    = '0;
               resp_d     = 2'b00;
               mismatch_d = 1'b0;
               timeout_d  = 1'b0;
            end
         end
         StWrReq: begin
            // AW and W retire independently; leave once neither is pending
            if (aw_pend_q && awready) aw_pend_d = 1'b0;
            if (w_pend_q && wready)   w_pend_d  = 1'b0;
            if (!aw_pend_d && !w_pend_d) state_d = StWrResp;
         end
         StWrResp: begin
            if (bvalid) begin
               resp_d  = bresp;
               state_d = StDone;
            end
         end
         StRdReq: begin
            if (arready) state_d = StRdData;
         end
         StRdData: begin
            if (rvalid) begin
               rdata_d    = rdata;
               resp_d     = rresp;
               mismatch_d = |((rdata ^ expected_q) & mask_q);
               state_d    = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // A handshake completing on the last allowed cycle wins over the timeout
      if (in_wait && (wait_cnt_q == LastCnt) && (state_d == state_q)) begin
         aw_pend_d  = 1'b0;
         w_pend_d   = 1'b0;
         rdata_d    = '0;
         resp_d     = 2'b10;
         mismatch_d = 1'b0;
         timeout_d  = 1'b1;
         state_d    = StDone;
      end

      test_fail_d = test_fail_q;
      if ((state_d == StDone) && (state_q != StDone) &&
          (mismatch_d || timeout_d || (resp_d != 2'b00))) begin
         test_fail_d = 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         mask_q      <= '0;
         expected_q  <= '0;
         aw_pend_q   <= 1'b0;
         w_pend_q    <= 1'b0;
         wait_cnt_q  <= '0;
         rdata_q     <= '0;
         resp_q      <= 2'b00;
         mismatch_q  <= 1'b0;
         timeout_q   <= 1'b0;
         test_fail_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         aw_pend_q   <= aw_pend_d;
         w_pend_q    <= w_pend_d;
         rdata_q     <= rdata_d;
         resp_q      <= resp_d;
         mismatch_q  <= mismatch_d;
         timeout_q   <= timeout_d;
         test_fail_q <= test_fail_d;
         if (accept) begin
            addr_q     <= cmd_addr;
            wdata_q    <= cmd_wdata;
            wstrb_q    <= cmd_wstrb;
            mask_q     <= cmd_mask;
            expected_q <= cmd_expected;
         end
         if (state_d != state_q) begin
            wait_cnt_q <= '0;
         end else if (in_wait) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
         end
      end
   end

   // cmd_ready is gated so every output reads 0 while reset is held
   assign cmd_ready    = (state_q == StIdle) && !areset;
   assign awaddr       = addr_q;
   assign awvalid      = aw_pend_q;
   assign wdata        = wdata_q;
   assign wstrb        = wstrb_q;
   assign wvalid       = w_pend_q;
   assign bready       = (state_q == StWrResp);
   assign araddr       = addr_q;
   assign arvalid      = (state_q == StRdReq);
   assign rready       = (state_q == StRdData);
   assign rsp_valid    = (state_q == StDone);
   assign rsp_rdata    = rdata_q;
   assign rsp_resp     = resp_q;
   assign rsp_mismatch = mismatch_q;
   assign rsp_timeout  = timeout_q;
   assign test_fail    = test_fail_q;

endmodule

// File: tb/tb_peripheral_bfm_master_axi4_lite.sv
// Directed and randomized bench for the AXI4-Lite BFM master against a configurable slave
// and a transaction-level reference model.
module tb_peripheral_bfm_master_axi4_lite;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 8;

   logic          aclk = 1'b0;
   logic          areset = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic [3:0]    cmd_wstrb = '0;
   logic [DW-1:0] cmd_mask = '0;
   logic [DW-1:0] cmd_expected = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_resp;
   logic          rsp_mismatch, rsp_timeout, test_fail;
   logic [AW-1:0] awaddr, araddr;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [DW-1:0] wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;

   always #5 aclk = ~aclk;

   peripheral_bfm_master_axi4_lite #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .aclk        (aclk),
      .areset      (areset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .cmd_wstrb   (cmd_wstrb),
      .cmd_mask    (cmd_mask),
      .cmd_expected(cmd_expected),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_resp    (rsp_resp),
      .rsp_mismatch(rsp_mismatch),
      .rsp_timeout (rsp_timeout),
      .test_fail   (test_fail),
      .awaddr      (awaddr),
      .awvalid     (awvalid),
      .awready     (awready),
      .wdata       (wdata),
      .wstrb       (wstrb),
      .wvalid      (wvalid),
      .wready      (wready),
      .bresp       (bresp),
      .bvalid      (bvalid),
      .bready      (bready),
      .araddr      (araddr),
      .arvalid     (arvalid),
      .arready     (arready),
      .rdata       (rdata),
      .rresp       (rresp),
      .rvalid      (rvalid),
      .rready      (rready)
   );

   int tests = 0;
   int fails = 0;
   int lat   = 0;
   bit tf_model = 1'b0;

   // slave configuration for the next transaction
   int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
   logic [1:0]  bresp_s = 2'b00, rresp_s = 2'b00;
   logic [31:0] rdata_s = '0;

   int   aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
   logic aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0;
   int   aw_beats = 0, w_beats = 0, ar_beats = 0, rsp_pulses = 0, ar_high = 0, viol = 0;
   logic p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_arv = 1'b0, p_arr = 1'b0;
   logic [31:0] p_awa = '0, p_ara = '0;
   logic [35:0] p_wd = '0;

   assign awready = (aw_cnt >= aw_dly);
   assign wready  = (w_cnt >= w_dly);
   assign arready = (ar_cnt >= ar_dly);
   assign bvalid  = aw_got && w_got && (b_cnt >= b_dly);
   assign rvalid  = ar_got && (r_cnt >= r_dly);
   assign bresp   = bresp_s;
   assign rresp   = rresp_s;
   assign rdata   = rdata_s;

   always @(posedge aclk) begin
      aw_beats   <= aw_beats + int'(awvalid && awready);
      w_beats    <= w_beats + int'(wvalid && wready);
      ar_beats   <= ar_beats + int'(arvalid && arready);
      rsp_pulses <= rsp_pulses + int'(rsp_valid);
      ar_high    <= ar_high + int'(arvalid);
      if (areset) begin
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
         p_awv <= 1'b0; p_wv <= 1'b0; p_arv <= 1'b0;
      end else begin
         if (awvalid && awready) begin aw_got <= 1'b1; aw_cnt <= 0; end
         else if (awvalid) aw_cnt <= aw_cnt + 1;
         else aw_cnt <= 0;
         if (wvalid && wready) begin w_got <= 1'b1; w_cnt <= 0; end
         else if (wvalid) w_cnt <= w_cnt + 1;
         else w_cnt <= 0;
         if (arvalid && arready) begin ar_got <= 1'b1; ar_cnt <= 0; end
         else if (arvalid) ar_cnt <= ar_cnt + 1;
         else ar_cnt <= 0;
         if (bvalid && bready) begin aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0; end
         else if (aw_got && w_got) b_cnt <= b_cnt + 1;
         if (rvalid && rready) begin ar_got <= 1'b0; r_cnt <= 0; end
         else if (ar_got) r_cnt <= r_cnt + 1;
         // pending valids must hold with stable payload (AR may legally drop on timeout)
         viol <= viol + int'(p_awv && !p_awr && (!awvalid || awaddr != p_awa))
                      + int'(p_wv && !p_wr && (!wvalid || {wdata, wstrb} != p_wd))
                      + int'(p_arv && !p_arr && arvalid && araddr != p_ara);
         p_awv <= awvalid; p_awr <= awready; p_awa <= awaddr;
         p_wv  <= wvalid;  p_wr  <= wready;  p_wd  <= {wdata, wstrb};
         p_arv <= arvalid; p_arr <= arready; p_ara <= araddr;
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input logic [31:0] mk, input logic [31:0] ex);
      int n = 0;
      while (!cmd_ready && n < 50) begin @(posedge aclk); #1; n++; end
      chk("cmd_ready_before_cmd", 64'(cmd_ready), 64'd1);
      cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st;
      cmd_mask = mk; cmd_expected = ex; cmd_valid = 1'b1;
      @(posedge aclk); #1;
      cmd_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 60) begin @(posedge aclk); #1; lat++; end
      chk("rsp_valid_arrives", 64'(rsp_valid), 64'd1);
   endtask

   task automatic expect_rsp(input string tag, input bit chk_rd, input logic [31:0] e_rd,
                             input logic [1:0] e_resp, input bit e_mm, input bit e_to);
      if (chk_rd) chk({tag, " rdata"}, 64'(rsp_rdata), 64'(e_rd));
      chk({tag, " resp"}, 64'(rsp_resp), 64'(e_resp));
      chk({tag, " mismatch"}, 64'(rsp_mismatch), 64'(e_mm));
      chk({tag, " timeout"}, 64'(rsp_timeout), 64'(e_to));
      tf_model = tf_model | e_mm | e_to | (e_resp != 2'b00);
      @(posedge aclk); #1;
      chk({tag, " single_pulse"}, 64'(rsp_valid), 64'd0);
      chk({tag, " test_fail"}, 64'(test_fail), 64'(tf_model));
      chk({tag, " back_to_idle"}, 64'(cmd_ready), 64'd1);
   endtask

   task automatic set_slave(input int a, input int w, input int ar, input int b, input int r);
      aw_dly = a; w_dly = w; ar_dly = ar; b_dly = b; r_dly = r;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, w0, ar0, p0, h0;
      bit          wr, mm;
      logic [31:0] addr, wd, mk, ex;
      logic [3:0]  st;

      // reset state
      repeat (3) @(posedge aclk);
      #1;
      chk("reset cmd_ready_held", 64'(cmd_ready), 64'd0);
      areset = 1'b0;
      @(posedge aclk); #1;
      chk("reset outputs", 64'({rsp_valid, awvalid, wvalid, bready, arvalid, rready, test_fail}),
          64'd0);
      chk("reset cmd_ready", 64'(cmd_ready), 64'd1);

      // basic write, all readies high
      set_slave(0, 0, 0, 0, 0); bresp_s = 2'b00;
      a0 = aw_beats; w0 = w_beats; p0 = rsp_pulses;
      txn(1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 32'h0, 32'h0);
      chk("wr0 latency", 64'(lat), 64'd3);
      expect_rsp("wr0", 1'b1, 32'h0, 2'b00, 1'b0, 1'b0);
      chk("wr0 aw_beats", 64'(aw_beats - a0), 64'd1);
      chk("wr0 w_beats", 64'(w_beats - w0), 64'd1);
      chk("wr0 rsp_pulses", 64'(rsp_pulses - p0), 64'd1);

      // W completes four cycles ahead of AW
      set_slave(5, 1, 0, 0, 0);
      a0 = aw_beats; w0 = w_beats; p0 = rsp_pulses;
      txn(1'b1, 32'h1004, 32'hCAFEF00D, 4'h3, 32'h0, 32'h0);
      expect_rsp("wr_split", 1'b1, 32'h0, 2'b00, 1'b0, 1'b0);
      chk("wr_split aw_beats", 64'(aw_beats - a0), 64'd1);
      chk("wr_split w_beats", 64'(w_beats - w0), 64'd1);
      chk("wr_split rsp_pulses", 64'(rsp_pulses - p0), 64'd1);
      chk("wr_split stability", 64'(viol), 64'd0);

      // masked read compare
      set_slave(0, 0, 0, 0, 0); rdata_s = 32'h12345678; rresp_s = 2'b00;
      txn(1'b0, 32'h2000, 32'h0, 4'h0, 32'hFFFF0000, 32'h12340000);
      chk("rd_match latency", 64'(lat), 64'd3);
      expect_rsp("rd_match", 1'b1, 32'h12345678, 2'b00, 1'b0, 1'b0);
      txn(1'b0, 32'h2000, 32'h0, 4'h0, 32'hFFFF0000, 32'h0);
      expect_rsp("rd_miss", 1'b1, 32'h12345678, 2'b00, 1'b1, 1'b0);

      // arready held low -> timeout
      set_slave(0, 0, 1000, 0, 0);
      h0 = ar_high; ar0 = ar_beats;
      txn(1'b0, 32'h3000, 32'h0, 4'h0, 32'h0, 32'h0);
      chk("rd_to latency", 64'(lat), 64'(TO + 1));
      chk("rd_to arvalid_cycles", 64'(ar_high - h0), 64'(TO));
      chk("rd_to ar_beats", 64'(ar_beats - ar0), 64'd0);
      expect_rsp("rd_to", 1'b0, 32'h0, 2'b10, 1'b0, 1'b1);
      set_slave(0, 0, 0, 0, 0);

      // reset while waiting for the write response
      b_dly = 1000;
      cmd_write = 1'b1; cmd_addr = 32'h4000; cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF;
      cmd_valid = 1'b1;
      @(posedge aclk); #1;
      cmd_valid = 1'b0;
      a0 = 0;
      while (!bready && a0 < 20) begin @(posedge aclk); #1; a0++; end
      chk("rst_mid in_wr_resp", 64'(bready), 64'd1);
      p0 = rsp_pulses;
      areset = 1'b1;
      @(posedge aclk); #1;
      chk("rst_mid outputs_zero",
          64'({cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready, test_fail,
               rsp_mismatch, rsp_timeout, rsp_resp}), 64'd0);
      chk("rst_mid addr_data_zero", {awaddr, wdata}, 64'd0);
      @(posedge aclk); #1;
      areset = 1'b0;
      tf_model = 1'b0;
      b_dly = 0;
      @(posedge aclk); #1;
      chk("rst_mid cmd_ready_after", 64'(cmd_ready), 64'd1);
      chk("rst_mid no_rsp", 64'(rsp_pulses - p0), 64'd0);

      // randomized traffic against the transaction model
      for (int i = 0; i < 40; i++) begin
         wr = 1'(($urandom & 1));
         addr = $urandom & 32'hFFFF_FFFC;
         wd = $urandom;
         st = 4'($urandom);
         rdata_s = $urandom;
         bresp_s = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         rresp_s = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         case ($urandom_range(0, 2))
            0: mk = 32'h0;
            1: mk = 32'hFFFF_FFFF;
            default: mk = $urandom;
         endcase
         ex = ($urandom_range(0, 1) == 0) ? rdata_s : $urandom;
         set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3));
         a0 = aw_beats; w0 = w_beats; ar0 = ar_beats; p0 = rsp_pulses;
         txn(wr, addr, wd, st, mk, ex);
         if (wr) begin
            expect_rsp("rnd_wr", 1'b1, 32'h0, bresp_s, 1'b0, 1'b0);
         end else begin
            mm = (((rdata_s ^ ex) & mk) != 32'h0);
            expect_rsp("rnd_rd", 1'b1, rdata_s, rresp_s, mm, 1'b0);
         end
         chk("rnd beats", 64'({aw_beats - a0, w_beats - w0, ar_beats - ar0}),
             wr ? 64'({32'd1, 32'd1, 32'd0}) : 64'({32'd0, 32'd0, 32'd1}));
         chk("rnd rsp_pulses", 64'(rsp_pulses - p0), 64'd1);
      end
      chk("stability overall", 64'(viol), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/peripheral_bfm_master_axi4_lite.md
PERIPHERAL_BFM_MASTER_AXI4_LITE -- requirements
Module: peripheral_bfm_master_axi4_lite

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width (32 or 64); STRB_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, maximum wait cycles per handshake (minimum 1).
REQ-004 aclk  in  1  single clock; all logic on rising edge.
REQ-005 areset  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  block idle and able to accept a command.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  ADDR_WIDTH  target address.
REQ-010 cmd_wdata  in  DATA_WIDTH  write data.
REQ-011 cmd_wstrb  in  STRB_WIDTH  write strobes.
REQ-012 cmd_mask  in  DATA_WIDTH  read-compare bit mask; all-zero disables the check.
REQ-013 rsp_valid  out  1  one-cycle pulse: transaction complete.
REQ-014 rsp_rdata  out  DATA_WIDTH  captured read data (0 for writes).
REQ-015 rsp_resp  out  2  captured BRESP/RRESP.
REQ-016 rsp_mismatch  out  1  masked read compare failed.
REQ-017 rsp_timeout  out  1  handshake exceeded TIMEOUT_CYCLES.
REQ-018 test_fail  out  1  sticky: any mismatch, timeout or non-OKAY response.
REQ-019 awaddr/awvalid  out  ADDR_WIDTH/1; awready  in  1.
REQ-020 wdata/wstrb/wvalid  out  DATA_WIDTH/STRB_WIDTH/1; wready  in  1.
REQ-021 bresp  in  2; bvalid  in  1; bready  out  1.
REQ-022 araddr/arvalid  out  ADDR_WIDTH/1; arready  in  1.
REQ-023 rdata  in  DATA_WIDTH; rresp  in  2; rvalid  in  1; rready  out  1.
REQ-024 cmd_expected  in  DATA_WIDTH  expected read data, compared under cmd_mask.

Function
REQ-025 FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE; one outstanding transaction.
REQ-026 cmd_ready=1 only in IDLE; command accepted on cmd_valid&&cmd_ready; all command fields registered that cycle.
REQ-027 WR_REQ: awvalid and wvalid asserted together next cycle; each deasserts independently on its own ready; AW and W may complete in either order or the same cycle; exit to WR_RESP when both done.
REQ-028 WR_RESP: bready=1; capture bresp on bvalid&&bready -> DONE. RD_REQ: arvalid=1 until arready -> RD_DATA; rready=1; capture rdata/rresp on rvalid&&rready -> DONE.
REQ-029 valid outputs SHALL NOT drop before handshake; address/data SHALL be held stable while valid is high.
REQ-030 DONE: rsp_valid pulses one cycle with captured results -> IDLE; minimum command-to-rsp_valid latency 3 cycles (all readies high).
REQ-031 rsp_mismatch = read && ((rdata ^ cmd_expected) & cmd_mask) != 0; always 0 for writes.
REQ-032 wait counter clears on each state entry and increments per cycle in WR_REQ/WR_RESP/RD_REQ/RD_DATA; on reaching TIMEOUT_CYCLES: drop all valids/readies, rsp_timeout=1, rsp_resp=2'b10, -> DONE.
REQ-033 test_fail set in DONE when rsp_mismatch, rsp_timeout or rsp_resp!=2'b00; cleared only by reset.

Reset
REQ-034 On areset (including mid-transaction): state IDLE, every output 0 next edge, counter cleared, no rsp_valid emitted for aborted transfer.

Verification
REQ-035 Write 0x1000/0xDEADBEEF/0xF, all readies high -> one AW and W beat, rsp_valid 3 cycles after accept, rsp_resp=0, test_fail=0.
REQ-036 Write with wready 4 cycles before awready -> AW and W complete separately, awaddr stable throughout, single rsp_valid.
REQ-037 Read 0x2000, rdata=0x12345678, expected 0x12340000, mask 0xFFFF0000 -> rsp_mismatch=0; expected 0x0 -> rsp_mismatch=1, test_fail=1.
REQ-038 TIMEOUT_CYCLES=8, arready held 0 -> arvalid drops after 8 cycles, rsp_timeout=1, rsp_resp=2'b10, test_fail=1.
REQ-039 areset asserted in WR_RESP -> outputs 0 next edge, no rsp_valid, cmd_ready=1 after release.
